// File: rtl/cv32e40p_cg_ctrl.sv
// cv32e40p_cg_ctrl
// -----------------------------------------------------------------------------
// Clock-enable controller for the core's latch-based clock gate. It runs on the
// free-running clock and decides when the gated domain may stop. The gate is
// entered only after an idle-hysteresis window with no busy work. Leaving the
// gate always goes through a fixed-length wake sequence with the clock running.
//
// Parameters:
//   IDLE_CYCLES    consecutive non-busy DRAIN cycles needed before gating (>=1)
//   WAKE_CYCLES    cycles spent in WAKE with the clock enabled before RUN (>=1)
//   CNT_W          width of the saturating gated-cycle counter
//
// Ports:
//   clk_i          free-running (ungated) clock
//   rst_ni         synchronous active-low reset
//   sleep_req_i    level request to gate the clock domain
//   busy_i         gated domain still has outstanding work
//   wake_i         level wake event (interrupt pending, debug request)
//   gated_clr_i    synchronous clear of gated_cycles_o
//   clk_en_o       enable to the clock gate, low only while in SLEEP
//   sleep_ack_o    high while in SLEEP
//   wake_done_o    one-cycle pulse on the first RUN cycle after WAKE
//   gated_cycles_o saturating count of cycles spent in SLEEP
// -----------------------------------------------------------------------------
module cv32e40p_cg_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sleep_req_i,
  input  logic             busy_i,
  input  logic             wake_i,
  input  logic             gated_clr_i,
  output logic             clk_en_o,
  output logic             sleep_ack_o,
  output logic             wake_done_o,
  output logic [CNT_W-1:0] gated_cycles_o
);

  // One counter serves both DRAIN and WAKE, so it is sized for the longer one.
  localparam int unsigned CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state and shared-counter logic. In DRAIN a wake event or a dropped
  // request aborts back to RUN before the clock ever stops. In DRAIN, busy work
  // restarts the idle window. WAKE ignores every input so it always completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (sleep_req_i && !wake_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (wake_i || !sleep_req_i) begin
          state_d = RUN;
        end else if (busy_i) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = SLEEP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SLEEP: begin
        if (wake_i || !sleep_req_i) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and outputs. The outputs are flops fed from the next state,
  // so clk_en_o changes only at a rising edge and never glitches during the
  // low phase, when the gate latch is transparent. The gated-cycle counter
  // counts cycles spent in SLEEP. A clear takes priority over a same-cycle
  // increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      clk_en_o       <= 1'b1;
      sleep_ack_o    <= 1'b0;
      wake_done_o    <= 1'b0;
      gated_cycles_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_o    <= (state_d != SLEEP);
      sleep_ack_o <= (state_d == SLEEP);
      wake_done_o <= (state_q == WAKE) && (state_d == RUN);
      if (gated_clr_i) begin
        gated_cycles_o <= '0;
      end else if ((state_q == SLEEP) && (gated_cycles_o != '1)) begin
        gated_cycles_o <= gated_cycles_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_cg_ctrl.sv
// tb_cv32e40p_cg_ctrl
// -----------------------------------------------------------------------------
// Directed bench for cv32e40p_cg_ctrl. There are two instances that share all
// inputs. One uses the default 32-bit counter and one uses a 4-bit counter, so
// the saturation behaviour is visible. A behavioural model tracks what mode the
// controller must be in. It also tracks how many idle/wake cycles have elapsed
// and the raw number of gated cycles. A compare process checks both instances
// against the model on every negative edge. The directed sequence also checks
// hand-computed values at the key cycles.
// -----------------------------------------------------------------------------
module tb_cv32e40p_cg_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sleep_req;
  logic        busy;
  logic        wake;
  logic        gated_clr;

  logic        en32, ack32, done32;
  logic [31:0] gated32;
  logic        en4, ack4, done4;
  logic [3:0]  gated4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cv32e40p_cg_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sleep_req_i(sleep_req), .busy_i(busy),
    .wake_i(wake), .gated_clr_i(gated_clr), .clk_en_o(en32),
    .sleep_ack_o(ack32), .wake_done_o(done32), .gated_cycles_o(gated32)
  );

  cv32e40p_cg_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .sleep_req_i(sleep_req), .busy_i(busy),
    .wake_i(wake), .gated_clr_i(gated_clr), .clk_en_o(en4),
    .sleep_ack_o(ack4), .wake_done_o(done4), .gated_cycles_o(gated4)
  );

  // Behavioural model. The clock is stopped exactly while m_asleep is set.
  // Entry requires IDLE consecutive quiet draining cycles. Exit passes through
  // WAKE cycles before a done pulse. m_gated is an unbounded count that each
  // instance saturates at its own width when it is compared.
  bit     m_valid = 1'b0;
  bit     m_draining, m_asleep, m_waking, m_done;
  int     idle_streak, wake_elapsed;
  longint m_gated;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid      <= 1'b1;
      m_draining   <= 1'b0;
      m_asleep     <= 1'b0;
      m_waking     <= 1'b0;
      m_done       <= 1'b0;
      idle_streak  <= 0;
      wake_elapsed <= 0;
      m_gated      <= 0;
    end else begin
      m_done <= 1'b0;
      if (gated_clr) m_gated <= 0;
      else if (m_asleep) m_gated <= m_gated + 1;
      if (m_draining) begin
        if (wake || !sleep_req) m_draining <= 1'b0;
        else if (busy) idle_streak <= 0;
        else if (idle_streak + 1 == IDLE) begin
          m_draining <= 1'b0;
          m_asleep   <= 1'b1;
        end else idle_streak <= idle_streak + 1;
      end else if (m_asleep) begin
        if (wake || !sleep_req) begin
          m_asleep     <= 1'b0;
          m_waking     <= 1'b1;
          wake_elapsed <= 0;
        end
      end else if (m_waking) begin
        if (wake_elapsed + 1 == WAKE) begin
          m_waking <= 1'b0;
          m_done   <= 1'b1;
        end else wake_elapsed <= wake_elapsed + 1;
      end else begin
        if (sleep_req && !wake) begin
          m_draining  <= 1'b1;
          idle_streak <= 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic w, input logic c);
    sleep_req = s;
    busy      = b;
    wake      = w;
    gated_clr = c;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [31:0] exp32;
      logic [31:0] exp4;
      exp32 = (m_gated > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_gated);
      exp4  = (m_gated > 15) ? 32'd15 : 32'(m_gated);
      checkOutput("model_en32",    {31'd0, en32},   {31'd0, !m_asleep});
      checkOutput("model_ack32",   {31'd0, ack32},  {31'd0, m_asleep});
      checkOutput("model_done32",  {31'd0, done32}, {31'd0, m_done});
      checkOutput("model_gated32", gated32,         exp32);
      checkOutput("model_en4",     {31'd0, en4},    {31'd0, !m_asleep});
      checkOutput("model_ack4",    {31'd0, ack4},   {31'd0, m_asleep});
      checkOutput("model_done4",   {31'd0, done4},  {31'd0, m_done});
      checkOutput("model_gated4",  {28'd0, gated4}, exp4);
    end
  end

  // Directed sequence. Inputs change at negative edges. The comment "cycle N"
  // means the negedge inside the cycle after rising edge N-1, where edge 0
  // samples the first change.
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held for three cycles with a sleep request present.
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkOutput("rst_en",    {31'd0, en32},  32'd1);
      checkOutput("rst_ack",   {31'd0, ack32}, 32'd0);
      checkOutput("rst_gated", gated32,        32'd0);
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(2);

    // Basic entry, followed by a wake at edge 20.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step(1);
      checkOutput("entry_drain_en", {31'd0, en32}, 32'd1);
    end
    step(1);
    checkOutput("entry_sleep_en",  {31'd0, en32},  32'd0);
    checkOutput("entry_sleep_ack", {31'd0, ack32}, 32'd1);
    step(15);
    checkOutput("sleep_gated_c20", gated32, 32'd15);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("wake_en_c21",    {31'd0, en32},  32'd1);
    checkOutput("wake_gated_c21", gated32,        32'd16);
    checkOutput("wake_sat4_c21",  {28'd0, gated4}, 32'd15);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("wake_done_c22", {31'd0, done32}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("wake_done_c23", {31'd0, done32}, 32'd1);
    step(1);
    checkOutput("wake_done_c24", {31'd0, done32}, 32'd0);
    checkOutput("redrain_en_c24", {31'd0, en32},  32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(2);

    // Synchronous clear while running.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("clr_gated32", gated32,         32'd0);
    checkOutput("clr_gated4",  {28'd0, gated4}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // Busy restart at cycle 3, then a clear issued during SLEEP.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    checkOutput("busy_en_c7", {31'd0, en32}, 32'd1);
    step(1);
    checkOutput("busy_en_c8", {31'd0, en32}, 32'd0);
    step(2);
    checkOutput("busy_gated_c10", gated32, 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("sleepclr_c11", gated32, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("sleepclr_c12", gated32, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(4);

    // Busy every other cycle: the idle window never completes.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, i[0], 1'b0, 1'b0);
      step(1);
      checkOutput("altbusy_en", {31'd0, en32}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // Abort from DRAIN by a wake event, then request and wake held together.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("abort_en_c3",  {31'd0, en32},  32'd1);
    checkOutput("abort_ack_c3", {31'd0, ack32}, 32'd0);
    step(3);
    checkOutput("both_en",    {31'd0, en32},  32'd1);
    checkOutput("both_ack",   {31'd0, ack32}, 32'd0);
    checkOutput("abort_gated", gated32,       32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(2);

    // Reset during SLEEP returns to RUN without a done pulse.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(6);
    checkOutput("rstsleep_ack", {31'd0, ack32}, 32'd1);
    rst_n = 1'b0;
    step(1);
    checkOutput("rstsleep_en",    {31'd0, en32},  32'd1);
    checkOutput("rstsleep_gated", gated32,        32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    checkOutput("rstsleep_nodone", {31'd0, done32}, 32'd0);

    // Long SLEEP: the 4-bit counter sticks at 15.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(30);
    checkOutput("long_gated32", gated32,         32'd25);
    checkOutput("long_gated4",  {28'd0, gated4}, 32'd15);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cv32e40p_cg_ctrl.md
# cv32e40p_cg_ctrl

Clock-enable controller that drives the enable input of the core's latch-based clock gate. It runs on the free-running clock, decides when the gated domain may stop, and produces the enable with an idle-hysteresis entry and a fixed-length wake sequence. It sits beside the clock gate in the core top level. Sleep requests, pipeline busy status and wake events come in; the gate enable, handshake acknowledges and a gated-cycle counter go out.

## Interface
- IDLE_CYCLES, default 4: consecutive non-busy cycles required in DRAIN before gating (legal ≥1).
- WAKE_CYCLES, default 2: cycles spent in WAKE with the clock enabled before RUN (legal ≥1).
- CNT_W, default 32: width of the gated-cycle counter.

Ports:
- clk_i  in  1  free-running (ungated) clock.
- rst_ni  in  1  reset, synchronous, active-low.
- sleep_req_i  in  1  level request to gate the clock domain.
- busy_i  in  1  gated domain has outstanding work (fetch, LSU, multicycle op).
- wake_i  in  1  level wake event (interrupt pending, debug request).
- gated_clr_i  in  1  synchronous clear of gated_cycles_o.
- clk_en_o  out  1  enable to the clock gate; 0 only in SLEEP.
- sleep_ack_o  out  1  high while in SLEEP.
- wake_done_o  out  1  one-cycle pulse on the first RUN cycle after WAKE.
- gated_cycles_o  out  CNT_W  count of cycles spent in SLEEP, saturating.

## Operation
- FSM states: RUN, DRAIN, SLEEP, WAKE. A single counter cnt, sized for max(IDLE_CYCLES, WAKE_CYCLES), is shared by DRAIN and WAKE.
- All outputs are registered and decoded from the state:
  - clk_en_o = (state != SLEEP).
  - sleep_ack_o = (state == SLEEP).
  - wake_done_o is high for the one cycle after WAKE→RUN.
- Reset (rst_ni=0 at an edge): state RUN, cnt 0, clk_en_o 1, sleep_ack_o 0, wake_done_o 0, gated_cycles_o 0.
- RUN:
  - sleep_req_i=1 and wake_i=0 → DRAIN, cnt←0.
  - Otherwise stay in RUN.
- DRAIN (wake_i has priority over everything else):
  - wake_i=1 or sleep_req_i=0 → RUN (abort; the clock never stops).
  - Else busy_i=1 → cnt←0.
  - Else cnt==IDLE_CYCLES-1 → SLEEP.
  - Else cnt←cnt+1.
- SLEEP:
  - wake_i=1 or sleep_req_i=0 → WAKE, cnt←0.
  - busy_i is ignored.
- WAKE:
  - cnt==WAKE_CYCLES-1 → RUN.
  - Else cnt←cnt+1.
  - sleep_req_i, wake_i and busy_i are ignored, so WAKE always runs to completion.
- gated_cycles_o:
  - Increments by 1 on every cycle the state is SLEEP.
  - Saturates at all-ones.
  - gated_clr_i=1 sets it to 0; clear wins over a same-cycle increment.

## Timing
- Entry latency: sleep_req_i sampled high at edge 0 gives DRAIN from cycle 1. With busy_i low continuously, SLEEP (clk_en_o=0) starts at cycle IDLE_CYCLES+1.
- Any busy_i=1 sample in DRAIN restarts the count. Entry then occurs IDLE_CYCLES cycles after the last busy cycle.
- Wake latency: wake_i sampled high in SLEEP at edge k gives clk_en_o=1 from cycle k+1. WAKE lasts cycles k+1 … k+WAKE_CYCLES. RUN starts with wake_done_o=1 at cycle k+WAKE_CYCLES+1.
- clk_en_o changes only at clk_i rising edges. It is stable for the whole low phase, which satisfies the gate latch's setup.
- sleep_req_i and wake_i both high in RUN or DRAIN: stay in or return to RUN, with no glitch on clk_en_o.
- Reset while in SLEEP or WAKE: RUN on the next edge, with clk_en_o=1 on that edge. No wake_done_o pulse is produced.
- sleep_req_i held high after a wake: RUN re-enters DRAIN on the following edge. The sleep/wake cycle repeats.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles with sleep_req_i=1 → clk_en_o=1, sleep_ack_o=0, gated_cycles_o=0 throughout.
- Basic entry (IDLE_CYCLES=4): sleep_req_i=1 at edge 0, busy_i=0 → clk_en_o=1 in cycles 1–4, then clk_en_o=0 and sleep_ack_o=1 at cycle 5.
- Busy restart: as above, but busy_i=1 at cycle 3 only → SLEEP at cycle 8. Busy_i=1 every other cycle → clk_en_o never drops.
- Abort: wake_i=1 at cycle 2 of DRAIN → RUN at cycle 3, clk_en_o stays 1, sleep_ack_o never asserts, gated_cycles_o=0.
- Wake (WAKE_CYCLES=2): wake_i=1 at edge k=20 while in SLEEP since cycle 5:
  - clk_en_o=1 at cycle 21.
  - wake_done_o=1 for exactly cycle 23.
  - gated_cycles_o=16.
  - A sleep_req_i toggle during cycles 21–22 has no effect.
- Counter: force gated_cycles_o near all-ones with CNT_W=4 over a long SLEEP → holds 15. gated_clr_i=1 in a SLEEP cycle → reads 0 the next cycle, then resumes counting.
